// File: rtl/pipe_pkg.sv
// Shared definitions for the integer-pipeline hazard controller: register
// width, controller state encoding, the NOP used by flush muxes and bank-control helpers.
package pipe_pkg;

  localparam int REG_BITS = 5;

  // addi x0, x0, 0 -- what a flushed pipeline-register bank loads in place of its d input
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } bank_ctrl_t;

  // Free-running pipeline: every bank loads, nothing squashed.
  function automatic bank_ctrl_t ctrl_run();
    bank_ctrl_t c;
    c.pc_en       = 1'b1;
    c.ifid_en     = 1'b1;
    c.idex_en     = 1'b1;
    c.exmem_en    = 1'b1;
    c.memwb_en    = 1'b1;
    c.ifid_flush  = 1'b0;
    c.idex_flush  = 1'b0;
    c.exmem_flush = 1'b0;
    return c;
  endfunction

  // Multiply in flight: front end holds, a bubble drains into EX/MEM.
  function automatic bank_ctrl_t ctrl_freeze();
    bank_ctrl_t c;
    c             = ctrl_run();
    c.pc_en       = 1'b0;
    c.ifid_en     = 1'b0;
    c.idex_en     = 1'b0;
    c.exmem_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs from the pipeline datapath and bank-control outputs of the
// stall controller. master = datapath side, slave = controller side.
interface pipe_stall_ctrl_if #(
  parameter int REG_BITS = pipe_pkg::REG_BITS,
  parameter int CNT_BITS = 32
);

  logic [REG_BITS-1:0] id_rs1;
  logic [REG_BITS-1:0] id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_is_load;
  logic                ex_mul_start;
  logic                branch_taken;

  logic                pc_en;
  logic                ifid_en;
  logic                idex_en;
  logic                exmem_en;
  logic                memwb_en;
  logic                ifid_flush;
  logic                idex_flush;
  logic                exmem_flush;
  logic                mul_busy;
  logic                mul_done;
  logic [CNT_BITS-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_mul_start, branch_taken,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, mul_busy, mul_done, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_mul_start, branch_taken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, mul_busy, mul_done, stall_cycles
  );

endinterface

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use detector: a load in EX writing a register the ID instruction reads.
// Purely combinational; r0 is hard-wired zero and never forms a hazard.
module hazard_detect #(
  parameter int REG_BITS = pipe_pkg::REG_BITS
) (
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_is_load,
  output logic                load_use
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_live  = ex_is_load && (ex_rd != '0);
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stall, multiplier
// freeze, branch squash, and a saturating stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int REG_BITS   = pipe_pkg::REG_BITS,
  parameter int CNT_BITS   = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  import pipe_pkg::*;

  localparam int MC_BITS = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  state_e              state_q;
  state_e              state_d;
  logic [MC_BITS-1:0]  cnt_q;
  logic [MC_BITS-1:0]  cnt_d;
  logic [CNT_BITS-1:0] stall_q;
  bank_ctrl_t          ctrl;
  logic                mul_done;
  logic                load_use;

  hazard_detect #(.REG_BITS(REG_BITS)) u_hazard_detect (
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .ex_rd      (bus.ex_rd),
    .ex_is_load (bus.ex_is_load),
    .load_use   (load_use)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl     = ctrl_run();
    mul_done = 1'b0;
    case (state_q)
      RUN: begin
        // Multiply outranks branch (decode makes them exclusive); branch outranks
        // load-use because the dependent instruction is squashed anyway.
        if (bus.ex_mul_start) begin
          state_d = MUL_WAIT;
          cnt_d   = MC_BITS'(MUL_CYCLES - 2);
          ctrl    = ctrl_freeze();
        end else if (bus.branch_taken) begin
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
        end else if (load_use) begin
          ctrl.pc_en      = 1'b0;
          ctrl.ifid_en    = 1'b0;
          ctrl.idex_flush = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (cnt_q != '0) begin
          ctrl  = ctrl_freeze();
          cnt_d = cnt_q - MC_BITS'(1);
        end else begin
          mul_done = 1'b1;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counts frozen-PC cycles; pins at all-ones so a long run never reads as short.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (!ctrl.pc_en && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_BITS'(1);
    end
  end

  assign bus.pc_en        = ctrl.pc_en;
  assign bus.ifid_en      = ctrl.ifid_en;
  assign bus.idex_en      = ctrl.idex_en;
  assign bus.exmem_en     = ctrl.exmem_en;
  assign bus.memwb_en     = ctrl.memwb_en;
  assign bus.ifid_flush   = ctrl.ifid_flush;
  assign bus.idex_flush   = ctrl.idex_flush;
  assign bus.exmem_flush  = ctrl.exmem_flush;
  assign bus.mul_busy     = (state_q == MUL_WAIT);
  assign bus.mul_done     = mul_done;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a reference model predicts each cycle's
// controls and stall counts; a 4-bit-counter instance exercises saturation.
module tb_pipe_stall_ctrl;

  localparam int MUL_CYCLES = 4;
  localparam int RB         = 5;

  typedef struct packed {
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, mul_busy, mul_done;
  } ctrl_t;

  typedef struct {
    ctrl_t       ctrl;
    logic [31:0] stall;
    logic [3:0]  stall4;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [RB-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_is_load = 1'b0;
  logic ex_mul_start = 1'b0, branch_taken = 1'b0;

  pipe_stall_ctrl_if #(.REG_BITS(RB), .CNT_BITS(32)) bus1 ();
  pipe_stall_ctrl_if #(.REG_BITS(RB), .CNT_BITS(4))  bus2 ();

  assign bus1.id_rs1 = id_rs1;             assign bus2.id_rs1 = id_rs1;
  assign bus1.id_rs2 = id_rs2;             assign bus2.id_rs2 = id_rs2;
  assign bus1.id_use_rs1 = id_use_rs1;     assign bus2.id_use_rs1 = id_use_rs1;
  assign bus1.id_use_rs2 = id_use_rs2;     assign bus2.id_use_rs2 = id_use_rs2;
  assign bus1.ex_rd = ex_rd;               assign bus2.ex_rd = ex_rd;
  assign bus1.ex_is_load = ex_is_load;     assign bus2.ex_is_load = ex_is_load;
  assign bus1.ex_mul_start = ex_mul_start; assign bus2.ex_mul_start = ex_mul_start;
  assign bus1.branch_taken = branch_taken; assign bus2.branch_taken = branch_taken;

  pipe_stall_ctrl #(.MUL_CYCLES(MUL_CYCLES), .REG_BITS(RB), .CNT_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  pipe_stall_ctrl #(.MUL_CYCLES(MUL_CYCLES), .REG_BITS(RB), .CNT_BITS(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  ctrl_t obs;
  assign obs = {bus1.pc_en, bus1.ifid_en, bus1.idex_en, bus1.exmem_en, bus1.memwb_en,
                bus1.ifid_flush, bus1.idex_flush, bus1.exmem_flush,
                bus1.mul_busy, bus1.mul_done};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_busy  = 1'b0;
  int          m_left  = 0;
  logic [31:0] m_stall = '0;
  int          m_stall4 = 0;

  exp_t sb[$];

  // Observed-event tallies for the multiply scenario
  int seen_busy, seen_pcz, seen_xflush, seen_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic [RB-1:0] rs1, input logic [RB-1:0] rs2,
                       input logic u1, input logic u2, input logic [RB-1:0] rd,
                       input logic ld, input logic mul, input logic br);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_mul_start = mul; branch_taken = br;
  endtask

  task automatic idle();
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic ctrl_t model_ctrl();
    ctrl_t c;
    bit    lu;
    lu = ex_is_load && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    c = '{pc_en:1, ifid_en:1, idex_en:1, exmem_en:1, memwb_en:1,
          ifid_flush:0, idex_flush:0, exmem_flush:0, mul_busy:m_busy, mul_done:0};
    if (m_busy) begin
      if (m_left > 0) begin
        c.pc_en = 0; c.ifid_en = 0; c.idex_en = 0; c.exmem_flush = 1;
      end else begin
        c.mul_done = 1;
      end
    end else if (ex_mul_start) begin
      c.pc_en = 0; c.ifid_en = 0; c.idex_en = 0; c.exmem_flush = 1;
    end else if (branch_taken) begin
      c.ifid_flush = 1; c.idex_flush = 1;
    end else if (lu) begin
      c.pc_en = 0; c.ifid_en = 0; c.idex_flush = 1;
    end
    return c;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_left = 0; m_stall = '0; m_stall4 = 0;
  endtask

  // One clock cycle: inputs already applied just after the previous edge.
  task automatic cycle(input string tag);
    ctrl_t c;
    exp_t  e;
    c = model_ctrl();
    e.ctrl = c; e.stall = m_stall; e.stall4 = 4'(m_stall4);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, ".ctrl"},   64'(obs),               64'(e.ctrl));
    check({tag, ".stall"},  64'(bus1.stall_cycles), 64'(e.stall));
    check({tag, ".stall4"}, 64'(bus2.stall_cycles), 64'(e.stall4));
    if (obs.mul_busy)    seen_busy++;
    if (!obs.pc_en)      seen_pcz++;
    if (obs.exmem_flush) seen_xflush++;
    if (obs.mul_done)    seen_done++;
    @(posedge clk);
    if (!c.pc_en) begin
      m_stall = m_stall + 1;
      if (m_stall4 < 15) m_stall4++;
    end
    if (m_busy) begin
      if (m_left > 0) m_left--;
      else m_busy = 0;
    end else if (ex_mul_start) begin
      m_busy = 1;
      m_left = MUL_CYCLES - 2;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s0;
    // Reset with arbitrary inputs applied
    drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy",  64'(bus1.mul_busy),     64'd0);
    check("rst.stall", 64'(bus1.stall_cycles), 64'd0);
    idle();
    @(negedge clk);
    check("rst.idle_ctrl", 64'(obs), 64'(ctrl_t'(10'b11111_00000)));
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    idle(); cycle("idle0");
    cycle("idle1");

    // Load-use on rs2: one stall cycle, then the bubble clears it
    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); cycle("lu_rs2");
    idle(); cycle("lu_after");
    check("lu.stall_is_1", 64'(bus1.stall_cycles), 64'd1);

    // r0 destination never hazards
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); cycle("lu_r0");
    // Matching register but operand unused
    drive(5'd9, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); cycle("lu_nouse");
    // Match but producer is not a load
    drive(5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0); cycle("nonload");
    // Load-use on rs1
    drive(5'd12, 5'd2, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0); cycle("lu_rs1");
    idle(); cycle("lu_rs1_after");

    // Branch overrides load-use
    s0 = bus1.stall_cycles;
    drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1); cycle("br_lu");
    idle(); cycle("br_after");
    check("br.stall_unchanged", 64'(bus1.stall_cycles), 64'(s0));

    // Multiply: hazard and branch inputs asserted while busy must be ignored
    s0 = bus1.stall_cycles;
    seen_busy = 0; seen_pcz = 0; seen_xflush = 0; seen_done = 0;
    drive('0, '0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0); cycle("mul_start");
    drive(5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); cycle("mul_w1");
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1); cycle("mul_w2");
    idle(); cycle("mul_rel");
    cycle("mul_post");
    check("mul.busy_cycles",   64'(seen_busy),   64'd3);
    check("mul.pc_en0_cycles", 64'(seen_pcz),    64'd3);
    check("mul.xflush_cycles", 64'(seen_xflush), 64'd3);
    check("mul.done_pulses",   64'(seen_done),   64'd1);
    check("mul.stall_delta",   64'(bus1.stall_cycles - s0), 64'd3);

    // Reset asserted during the second busy cycle
    seen_done = 0;
    drive('0, '0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0); cycle("mulr_start");
    idle(); cycle("mulr_w1");
    rst = 1'b0;
    #1;
    check("mulr.busy_async", 64'(bus1.mul_busy),     64'd0);
    check("mulr.done",       64'(bus1.mul_done),     64'd0);
    check("mulr.stall",      64'(bus1.stall_cycles), 64'd0);
    model_reset();
    @(negedge clk);
    check("mulr.done_hold", 64'(bus1.mul_done), 64'd0);
    check("mulr.ctrl_hold", 64'(obs), 64'(ctrl_t'(10'b11111_00000)));
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle("mulr_idle");
    check("mulr.no_done", 64'(seen_done), 64'd0);

    // Saturation of the 4-bit instance under a held hazard
    drive(5'd1, 5'd6, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle($sformatf("sat%0d", i));
    idle(); cycle("sat_end");
    check("sat.stall4_is_15", 64'(bus2.stall_cycles), 64'd15);
    check("sat.stall32_is_20", 64'(bus1.stall_cycles), 64'd20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
